// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and the
// error codes reported on err_code.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_CHK     = 2'b11;

endpackage

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// as big-endian words and keeps the CPU in reset until a load succeeds.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 65535,
    parameter bit BOOT_HOLD   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_written
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [15:0]       TLIM     = 16'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t      state;
    state_t      state_next;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [7:0]  xor_acc;
    logic [15:0] tcnt;
    logic        set_err;
    logic [1:0]  err_val;

    logic        xfer;
    logic        start_ok;
    logic [15:0] hdr_len;
    logic        len_bad;
    logic        last_word;
    logic        timeout_hit;

    assign xfer        = byte_valid & byte_ready;
    assign start_ok    = start && (state == IDLE || state == DONE || state == ERR);
    assign hdr_len     = {len_hi, byte_data};
    assign len_bad     = (hdr_len == 16'd0) || (32'(hdr_len) > DEPTH);
    assign last_word   = (32'(words_written) + 32'd1) == 32'(len);
    assign timeout_hit = !xfer && (tcnt == TLIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Outputs are decoded from state so imem_we falls the instant rst hits.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        set_err    = 1'b0;
        err_val    = ERR_NONE;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                cpu_hold = BOOT_HOLD;
                if (start) state_next = HDR_HI;
            end
            DONE: begin
                busy     = 1'b0;
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) state_next = HDR_HI;
            end
            ERR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (start) state_next = HDR_HI;
            end
            HDR_HI: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    state_next = HDR_LO;
                end else if (timeout_hit) begin
                    state_next = ERR;
                    set_err    = 1'b1;
                    err_val    = ERR_TIMEOUT;
                end
            end
            HDR_LO: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    if (len_bad) begin
                        state_next = ERR;
                        set_err    = 1'b1;
                        err_val    = ERR_LEN;
                    end else begin
                        state_next = DATA;
                    end
                end else if (timeout_hit) begin
                    state_next = ERR;
                    set_err    = 1'b1;
                    err_val    = ERR_TIMEOUT;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    if (byte_idx == 2'd3) state_next = WRITE;
                end else if (timeout_hit) begin
                    state_next = ERR;
                    set_err    = 1'b1;
                    err_val    = ERR_TIMEOUT;
                end
            end
            WRITE: begin
                imem_we    = 1'b1;
                state_next = last_word ? CHK : DATA;
            end
            CHK: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    if (byte_data == xor_acc) begin
                        state_next = DONE;
                    end else begin
                        state_next = ERR;
                        set_err    = 1'b1;
                        err_val    = ERR_CHK;
                    end
                end else if (timeout_hit) begin
                    state_next = ERR;
                    set_err    = 1'b1;
                    err_val    = ERR_TIMEOUT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The idle counter only runs while a byte could be accepted, so it is
    // naturally zero on entry to WRITE and in the resting states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi        <= 8'd0;
            len           <= 16'd0;
            byte_idx      <= 2'd0;
            xor_acc       <= 8'd0;
            tcnt          <= 16'd0;
            imem_waddr    <= '0;
            imem_wdata    <= 32'd0;
            words_written <= '0;
            err_code      <= ERR_NONE;
        end else begin
            if (byte_ready) tcnt <= xfer ? 16'd0 : tcnt + 16'd1;
            else            tcnt <= 16'd0;

            if (start_ok) begin
                byte_idx      <= 2'd0;
                xor_acc       <= 8'd0;
                tcnt          <= 16'd0;
                imem_waddr    <= '0;
                words_written <= '0;
                err_code      <= ERR_NONE;
            end else begin
                case (state)
                    HDR_HI: if (xfer) len_hi <= byte_data;
                    HDR_LO: if (xfer) len <= hdr_len;
                    DATA: begin
                        if (xfer) begin
                            imem_wdata <= {imem_wdata[23:0], byte_data};
                            xor_acc    <= xor_acc ^ byte_data;
                            byte_idx   <= byte_idx + 2'd1;
                        end
                    end
                    WRITE: begin
                        imem_waddr    <= imem_waddr + ADDR_ONE;
                        words_written <= words_written + CNT_ONE;
                    end
                    default: ;
                endcase
                if (set_err) err_code <= err_val;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// scored against a frame-level model of the expected memory writes and outcome.
module tb_imem_loader;

    localparam int ADDR_W = 12;
    localparam int TCYC   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_written;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc_cyc = -10;
    int lat_bad = 0;
    int rdy_bad = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    logic [7:0]        frame[$];
    logic [ADDR_W-1:0] ea_q[$];
    logic [31:0]       ed_q[$];
    logic              exp_done;
    logic [1:0]        exp_code;
    int                exp_words;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TCYC), .BOOT_HOLD(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Observes memory writes and handshake timing between edges.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            wa_q.push_back(imem_waddr);
            wd_q.push_back(imem_wdata);
            if (cyc != last_acc_cyc) lat_bad++;
            if (byte_ready) rdy_bad++;
        end
        if (byte_valid && byte_ready) last_acc_cyc = cyc + 1;
    end

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        wa_q.delete();
        wd_q.delete();
        lat_bad = 0;
        rdy_bad = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        waited = 0;
        while (!byte_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL byte_ready_wait: got ready=0 after %0d cycles, want ready=1", waited);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input int gapmax);
        for (int i = from; i < to; i++) send_byte(frame[i], $urandom_range(gapmax, 0));
    endtask

    // Header, n random big-endian words, then checksum XORed with corrupt.
    task automatic build_frame(input int n, input logic [7:0] corrupt);
        logic [7:0] x;
        logic [15:0] n16;
        x = 8'd0;
        n16 = 16'(n);
        frame.delete();
        frame.push_back(n16[15:8]);
        frame.push_back(n16[7:0]);
        for (int i = 0; i < 4 * n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            frame.push_back(b);
            x = x ^ b;
        end
        frame.push_back(x ^ corrupt);
    endtask

    // Expected outcome derived purely from the frame contents.
    task automatic model_frame();
        int n;
        logic [7:0] x;
        ea_q.delete();
        ed_q.delete();
        n = {frame[0], frame[1]};
        x = 8'd0;
        if (n == 0 || n > 2 ** ADDR_W) begin
            exp_done  = 1'b0;
            exp_code  = 2'b01;
            exp_words = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            ea_q.push_back(ADDR_W'(i));
            ed_q.push_back({frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]});
            for (int k = 0; k < 4; k++) x = x ^ frame[2+4*i+k];
        end
        exp_words = n;
        exp_done  = (frame[2+4*n] == x);
        exp_code  = exp_done ? 2'b00 : 2'b11;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({byte_ready, imem_we, busy, done, err, cpu_hold} !== 6'b000001) begin
            n_bad++;
            $display("[TB] FAIL reset_flags: got %b want 000001",
                     {byte_ready, imem_we, busy, done, err, cpu_hold});
        end
        n_cmp++;
        if ({imem_waddr, imem_wdata, err_code, words_written} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_values: got waddr=%h wdata=%h code=%b words=%0d want all 0",
                     imem_waddr, imem_wdata, err_code, words_written);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        n_cmp++;
        if ({byte_ready, busy} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL idle_no_accept: got ready/busy=%b want 00", {byte_ready, busy});
        end
    endtask

    task automatic test_load_n2(input int gapmax, input string tag);
        frame.delete();
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
        frame.push_back(8'h2D ^ 8'hA9);
        clear_obs();
        pulse_start();
        for (int i = 0; i < frame.size(); i++) send_byte(frame[i], gapmax);
        n_cmp++;
        if (wa_q.size() != 2) begin
            n_bad++;
            $display("[TB] FAIL %s_write_count: got %0d want 2", tag, wa_q.size());
        end else begin
            n_cmp++;
            if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== {12'd0, 32'h20080005, 12'd1, 32'hAC010004}) begin
                n_bad++;
                $display("[TB] FAIL %s_writes: got %h:%h %h:%h want 000:20080005 001:ac010004",
                         tag, wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
            end
        end
        n_cmp++;
        if ({done, err, cpu_hold, busy, words_written} !== {4'b1000, 13'd2}) begin
            n_bad++;
            $display("[TB] FAIL %s_status: got done=%b err=%b hold=%b busy=%b words=%0d want 1 0 0 0 2",
                     tag, done, err, cpu_hold, busy, words_written);
        end
        n_cmp++;
        if (lat_bad != 0 || rdy_bad != 0) begin
            n_bad++;
            $display("[TB] FAIL %s_we_timing: got late=%0d ready_in_write=%0d want 0 0",
                     tag, lat_bad, rdy_bad);
        end
    endtask

    task automatic test_bad_length();
        logic [7:0] hdr [3][2];
        logic [1:0] want_code [3];
        hdr = '{'{8'h00, 8'h00}, '{8'h10, 8'h01}, '{8'hFF, 8'hFF}};
        for (int t = 0; t < 3; t++) begin
            clear_obs();
            pulse_start();
            send_byte(hdr[t][0], 0);
            send_byte(hdr[t][1], 0);
            n_cmp++;
            if ({err, done, busy, cpu_hold, err_code} !== 6'b100101 || wa_q.size() != 0) begin
                n_bad++;
                $display("[TB] FAIL bad_len_%0d: got err=%b done=%b busy=%b hold=%b code=%b writes=%0d want 1 0 0 1 01 0",
                         t, err, done, busy, cpu_hold, err_code, wa_q.size());
            end
        end
        // Exactly the full memory depth is still a legal length.
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        n_cmp++;
        if ({err, busy, byte_ready} !== 3'b011) begin
            n_bad++;
            $display("[TB] FAIL len_max_ok: got err=%b busy=%b ready=%b want 0 1 1", err, busy, byte_ready);
        end
        apply_reset();
    endtask

    task automatic test_checksum();
        build_frame(1, 8'h01);
        clear_obs();
        pulse_start();
        send_range(0, frame.size(), 0);
        n_cmp++;
        if (wa_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL chk_write_count: got %0d want 1", wa_q.size());
        end
        n_cmp++;
        if ({err, done, cpu_hold, err_code, words_written} !== {3'b101, 2'b11, 13'd1}) begin
            n_bad++;
            $display("[TB] FAIL chk_status: got err=%b done=%b hold=%b code=%b words=%0d want 1 0 1 11 1",
                     err, done, cpu_hold, err_code, words_written);
        end
    endtask

    task automatic test_timeout();
        build_frame(2, 8'h00);
        clear_obs();
        pulse_start();
        send_range(0, 5, 0);
        repeat (TCYC - 1) @(negedge clk);
        n_cmp++;
        if ({err, busy} !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL timeout_early: got err=%b busy=%b want 0 1", err, busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({err, err_code, cpu_hold, busy} !== 5'b11010 || wa_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL timeout_err: got err=%b code=%b hold=%b busy=%b writes=%0d want 1 10 1 0 0",
                     err, err_code, cpu_hold, busy, wa_q.size());
        end
        build_frame(1, 8'h00);
        model_frame();
        clear_obs();
        pulse_start();
        send_range(0, frame.size(), 1);
        n_cmp++;
        if ({done, err, err_code} !== 4'b1000 || wa_q.size() != 1 || wd_q[0] !== ed_q[0]) begin
            n_bad++;
            $display("[TB] FAIL timeout_recover: got done=%b err=%b code=%b writes=%0d want 1 0 00 1",
                     done, err, err_code, wa_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        build_frame(1, 8'h00);
        clear_obs();
        pulse_start();
        send_range(0, 6, 0);
        n_cmp++;
        if (imem_we !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL pre_rst_we: got %b want 1", imem_we);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({imem_we, byte_ready, busy, done, err, cpu_hold} !== 6'b000001 ||
            {imem_waddr, imem_wdata, err_code, words_written} !== '0) begin
            n_bad++;
            $display("[TB] FAIL async_rst: got we=%b ready=%b busy=%b hold=%b waddr=%h wdata=%h words=%0d want 0 0 0 1 0 0 0",
                     imem_we, byte_ready, busy, cpu_hold, imem_waddr, imem_wdata, words_written);
        end
        @(negedge clk);
        rst = 1'b0;

        build_frame(2, 8'h00);
        model_frame();
        clear_obs();
        pulse_start();
        send_range(0, 6, 0);
        @(negedge clk);
        pulse_start();
        n_cmp++;
        if ({busy, words_written} !== {1'b1, 13'd1}) begin
            n_bad++;
            $display("[TB] FAIL start_ignored: got busy=%b words=%0d want 1 1", busy, words_written);
        end
        send_range(6, frame.size(), 0);
        n_cmp++;
        if (done !== 1'b1 || wa_q.size() != 2 || wd_q[1] !== ed_q[1]) begin
            n_bad++;
            $display("[TB] FAIL start_ignored_finish: got done=%b writes=%0d want 1 2", done, wa_q.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int sel;
            sel = $urandom_range(7, 0);
            if (sel == 0) begin
                frame.delete();
                frame.push_back(8'h00);
                frame.push_back(8'h00);
            end else if (sel == 1) begin
                frame.delete();
                frame.push_back(8'($urandom_range(255, 16)));
                frame.push_back(8'($urandom_range(255, 1)));
            end else begin
                build_frame($urandom_range(6, 1), (sel < 4) ? 8'($urandom_range(255, 1)) : 8'h00);
            end
            model_frame();
            clear_obs();
            pulse_start();
            send_range(0, frame.size(), 2);
            n_cmp++;
            if ({done, err, err_code, cpu_hold} !== {exp_done, !exp_done, exp_code, !exp_done} ||
                32'(words_written) != exp_words) begin
                n_bad++;
                $display("[TB] FAIL rand_%0d_status: got done=%b err=%b code=%b hold=%b words=%0d want %b %b %b %b %0d",
                         it, done, err, err_code, cpu_hold, words_written,
                         exp_done, !exp_done, exp_code, !exp_done, exp_words);
            end
            n_cmp++;
            if (wa_q.size() != ea_q.size()) begin
                n_bad++;
                $display("[TB] FAIL rand_%0d_write_count: got %0d want %0d", it, wa_q.size(), ea_q.size());
            end else begin
                for (int i = 0; i < ea_q.size(); i++) begin
                    n_cmp++;
                    if ({wa_q[i], wd_q[i]} !== {ea_q[i], ed_q[i]}) begin
                        n_bad++;
                        $display("[TB] FAIL rand_%0d_write_%0d: got %h:%h want %h:%h",
                                 it, i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
                    end
                end
            end
            n_cmp++;
            if (lat_bad != 0 || rdy_bad != 0) begin
                n_bad++;
                $display("[TB] FAIL rand_%0d_we_timing: got late=%0d ready_in_write=%0d want 0 0",
                         it, lat_bad, rdy_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_n2(0, "load_n2");
        test_load_n2(1, "back_pressure");
        test_bad_length();
        test_checksum();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "[TB] global time limit reached");
    end

endmodule
